ysyx_25040109_mem_arb: RTL and testbench
========================================

# ysyx_25040109_mem_arb

Parametrised N-channel round-robin arbiter that merges the core's instruction-fetch and load/store request streams, plus any later masters, onto one shared memory port. Each channel and the downstream port use a valid/ready request phase and a valid/ready response phase. Exactly one transaction is outstanding at a time. A per-transaction watchdog returns an error response if memory never answers.

## Interface
- NCH, 2: number of upstream channels (≥2); channel 0 is the IFU and channel 1 is the LSU.
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 255: response watchdog limit in cycles; 0 disables the watchdog.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low (asserted when rst=0, sampled on clk).
- m_req_valid  in  NCH  per-channel request valid.
- m_req_ready  out  NCH  per-channel request accepted.
- m_req_wen  in  NCH  1 = write, 0 = read.
- m_req_addr  in  NCH*AW  channel i at bits [i*AW +: AW].
- m_req_wdata  in  NCH*DW  write data, same packing as m_req_addr.
- m_req_wlen  in  NCH*3  write byte length code, passed through unchanged.
- m_rsp_valid  out  NCH  response valid for the owning channel.
- m_rsp_ready  in  NCH  channel accepts the response.
- m_rsp_rdata  out  DW  read data, shared by all channels; meaningful only where m_rsp_valid=1.
- m_rsp_err  out  1  response is a watchdog error.
- s_req_valid / s_req_ready  out/in  1  downstream request handshake.
- s_req_wen, s_req_addr, s_req_wdata, s_req_wlen  out  1/AW/DW/3  registered request payload.
- s_rsp_valid / s_rsp_ready  in/out  1  downstream response handshake.
- s_rsp_rdata  in  DW  downstream read data.
- busy  out  1  a transaction is in flight (state ≠ IDLE).
- owner  out  clog2(NCH)  index of the channel currently granted.

## Operation
- FSM states: IDLE, REQ, RSP, ERR.
- IDLE
  - Selection scans channels starting at rr_ptr and going up modulo NCH; the first channel with m_req_valid=1 is selected.
  - m_req_ready of the selected channel is high combinationally; all other m_req_ready bits are 0.
  - On that edge:
    - latch wen, addr, wdata and wlen;
    - owner ← selected channel;
    - clear the watchdog counter;
    - go to REQ.
- REQ
  - s_req_valid=1 with the latched payload.
  - On s_req_ready=1, go to RSP.
  - The watchdog counts from entry to REQ.
- RSP
  - m_rsp_valid[owner]=s_rsp_valid, m_rsp_rdata=s_rsp_rdata, s_rsp_ready=m_rsp_ready[owner].
  - When both are high:
    - rr_ptr ← (owner+1) mod NCH;
    - go to IDLE.
- Watchdog (TIMEOUT≠0): the counter increments every cycle in REQ and RSP.
  - When it reaches TIMEOUT with no completing handshake in that cycle, go to ERR.
  - The counter saturates and never wraps.
- ERR
  - m_rsp_valid[owner]=1, m_rsp_err=1, m_rsp_rdata=0.
  - s_req_valid=0, s_rsp_ready=0.
  - On m_rsp_ready[owner], advance rr_ptr and go to IDLE.
  - A late s_rsp_valid is ignored; no downstream response is consumed.
- m_rsp_err=0 in every state other than ERR.
- Upstream masters hold valid and payload stable until ready. Payload changes after acceptance have no effect.

## Timing
- Reset values (rst=0):
  - state=IDLE, rr_ptr=0, owner=0, busy=0;
  - s_req_valid=0, s_rsp_ready=0;
  - all m_rsp_valid=0, m_rsp_err=0, counter=0;
  - latched payload=0.
- Reset mid-transaction abandons the transaction. No response is forwarded and the next grant starts from channel 0.
- Best-case latency with zero-wait memory:
  - cycle 0: accept;
  - cycle 1: s_req_valid high;
  - earliest m_rsp_valid in cycle 2.
- Back-to-back: the next grant can happen in the cycle after response completion (IDLE lasts ≥1 cycle). Throughput is therefore at most one transaction per 3 cycles.
- No combinational path from s_req_ready to m_req_ready. There is a combinational path s_rsp_valid→m_rsp_valid and m_rsp_ready→s_rsp_ready (pass-through).
- Counter reaching TIMEOUT in the same cycle as a completing handshake: the handshake wins and ERR is not entered.
- Wrap-around: owner=NCH-1 sets rr_ptr to 0.

## Test plan
- Single read: ch0 requests addr 0x80000000; memory has ready=1 and returns 0x00000413 after 2 cycles.
  - Expect ch0 m_rsp_valid with rdata 0x00000413, err=0, busy=0 afterwards.
  - Expect m_req_ready[1] never high.
- Contention, NCH=2: both channels request continuously.
  - Expect grants in order 0,1,0,1.
  - Expect s_req_addr to alternate 0x80000000 / 0xa0000000 and no channel to be starved.
- Wrap, NCH=4: only ch3 then ch0 request.
  - Expect rr_ptr 0→... after ch3 grant rr_ptr=0, then ch0 granted next.
- Write: ch1 writes wdata 0xdeadbeef with wlen 3'b100.
  - Expect s_req_* to match exactly.
  - Expect response with err=0 on s_rsp_valid.
- Timeout, TIMEOUT=4: memory accepts but never responds.
  - Expect ERR 4 cycles after REQ entry, m_rsp_err=1, rdata=0, then IDLE.
  - Expect a late s_rsp_valid to be ignored (s_rsp_ready=0).
- Reset mid-RSP: drive rst=0 for 1 cycle while busy.
  - Expect all outputs at reset values the next cycle.
  - Expect the next grant to go to ch0 when both request.

Source files
------------

// File: rtl/ysyx_25040109_mem_arb.sv
// Round-robin arbiter merging N request/response channels onto one memory port.
// One transaction in flight at a time, with a response watchdog.
module ysyx_25040109_mem_arb #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          m_req_valid,
    output logic [NCH-1:0]          m_req_ready,
    input  logic [NCH-1:0]          m_req_wen,
    input  logic [NCH*AW-1:0]       m_req_addr,
    input  logic [NCH*DW-1:0]       m_req_wdata,
    input  logic [NCH*3-1:0]        m_req_wlen,
    output logic [NCH-1:0]          m_rsp_valid,
    input  logic [NCH-1:0]          m_rsp_ready,
    output logic [DW-1:0]           m_rsp_rdata,
    output logic                    m_rsp_err,
    output logic                    s_req_valid,
    input  logic                    s_req_ready,
    output logic                    s_req_wen,
    output logic [AW-1:0]           s_req_addr,
    output logic [DW-1:0]           s_req_wdata,
    output logic [2:0]              s_req_wlen,
    input  logic                    s_rsp_valid,
    output logic                    s_rsp_ready,
    input  logic [DW-1:0]           s_rsp_rdata,
    output logic                    busy,
    output logic [$clog2(NCH)-1:0]  owner
);

    localparam int OW = $clog2(NCH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        ERR
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [2:0]      wlen_q, wlen_d;

    logic            sel_found;
    logic [OW-1:0]   sel_idx;
    logic [CW-1:0]   cnt_inc;
    logic            wd_hit;
    logic [OW-1:0]   next_ptr;

    // Scan channels upward from rr_ptr, wrapping at NCH (need not be a power of 2).
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!sel_found && m_req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = OW'(idx);
            end
        end
    end

    // Saturating watchdog; a hit means the counter reaches TIMEOUT on this edge.
    always_comb begin
        cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
        wd_hit  = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    end

    assign next_ptr = (owner_q == OW'(NCH - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wlen_d      = wlen_q;
        m_req_ready = '0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        m_rsp_err   = 1'b0;
        s_req_valid = 1'b0;
        s_rsp_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    m_req_ready[sel_idx] = 1'b1;
                    wen_d   = m_req_wen[sel_idx];
                    addr_d  = m_req_addr[int'(sel_idx)*AW +: AW];
                    wdata_d = m_req_wdata[int'(sel_idx)*DW +: DW];
                    wlen_d  = m_req_wlen[int'(sel_idx)*3 +: 3];
                    owner_d = sel_idx;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_valid = 1'b1;
                if (TIMEOUT != 0) cnt_d = cnt_inc;
                if (s_req_ready) begin
                    state_d = RSP;
                end else if (wd_hit) begin
                    state_d = ERR;
                end
            end
            RSP: begin
                m_rsp_valid[owner_q] = s_rsp_valid;
                m_rsp_rdata          = s_rsp_rdata;
                s_rsp_ready          = m_rsp_ready[owner_q];
                if (TIMEOUT != 0) cnt_d = cnt_inc;
                if (s_rsp_valid && m_rsp_ready[owner_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (wd_hit) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                m_rsp_valid[owner_q] = 1'b1;
                m_rsp_err            = 1'b1;
                if (m_rsp_ready[owner_q]) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wlen_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wlen_q   <= wlen_d;
        end
    end

    assign s_req_wen   = wen_q;
    assign s_req_addr  = addr_q;
    assign s_req_wdata = wdata_q;
    assign s_req_wlen  = wlen_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_ysyx_25040109_mem_arb.sv
// Directed bench: dut_a is 2 channels with a 4-cycle watchdog,
// dut_b is 4 channels with the watchdog disabled.
module tb_ysyx_25040109_mem_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [1:0]  a_m_req_valid, a_m_req_ready, a_m_req_wen;
    logic [63:0] a_m_req_addr, a_m_req_wdata;
    logic [5:0]  a_m_req_wlen;
    logic [1:0]  a_m_rsp_valid, a_m_rsp_ready;
    logic [31:0] a_m_rsp_rdata;
    logic        a_m_rsp_err;
    logic        a_s_req_valid, a_s_req_ready, a_s_req_wen;
    logic [31:0] a_s_req_addr, a_s_req_wdata;
    logic [2:0]  a_s_req_wlen;
    logic        a_s_rsp_valid, a_s_rsp_ready;
    logic [31:0] a_s_rsp_rdata;
    logic        a_busy;
    logic [0:0]  a_owner;

    logic [3:0]   b_m_req_valid, b_m_req_ready, b_m_req_wen;
    logic [127:0] b_m_req_addr, b_m_req_wdata;
    logic [11:0]  b_m_req_wlen;
    logic [3:0]   b_m_rsp_valid, b_m_rsp_ready;
    logic [31:0]  b_m_rsp_rdata;
    logic         b_m_rsp_err;
    logic         b_s_req_valid, b_s_req_ready, b_s_req_wen;
    logic [31:0]  b_s_req_addr, b_s_req_wdata;
    logic [2:0]   b_s_req_wlen;
    logic         b_s_rsp_valid, b_s_rsp_ready;
    logic [31:0]  b_s_rsp_rdata;
    logic         b_busy;
    logic [1:0]   b_owner;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25040109_mem_arb #(.NCH(2), .AW(32), .DW(32), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .m_req_valid(a_m_req_valid), .m_req_ready(a_m_req_ready),
        .m_req_wen(a_m_req_wen), .m_req_addr(a_m_req_addr),
        .m_req_wdata(a_m_req_wdata), .m_req_wlen(a_m_req_wlen),
        .m_rsp_valid(a_m_rsp_valid), .m_rsp_ready(a_m_rsp_ready),
        .m_rsp_rdata(a_m_rsp_rdata), .m_rsp_err(a_m_rsp_err),
        .s_req_valid(a_s_req_valid), .s_req_ready(a_s_req_ready),
        .s_req_wen(a_s_req_wen), .s_req_addr(a_s_req_addr),
        .s_req_wdata(a_s_req_wdata), .s_req_wlen(a_s_req_wlen),
        .s_rsp_valid(a_s_rsp_valid), .s_rsp_ready(a_s_rsp_ready),
        .s_rsp_rdata(a_s_rsp_rdata), .busy(a_busy), .owner(a_owner)
    );

    ysyx_25040109_mem_arb #(.NCH(4), .AW(32), .DW(32), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst),
        .m_req_valid(b_m_req_valid), .m_req_ready(b_m_req_ready),
        .m_req_wen(b_m_req_wen), .m_req_addr(b_m_req_addr),
        .m_req_wdata(b_m_req_wdata), .m_req_wlen(b_m_req_wlen),
        .m_rsp_valid(b_m_rsp_valid), .m_rsp_ready(b_m_rsp_ready),
        .m_rsp_rdata(b_m_rsp_rdata), .m_rsp_err(b_m_rsp_err),
        .s_req_valid(b_s_req_valid), .s_req_ready(b_s_req_ready),
        .s_req_wen(b_s_req_wen), .s_req_addr(b_s_req_addr),
        .s_req_wdata(b_s_req_wdata), .s_req_wlen(b_s_req_wlen),
        .s_rsp_valid(b_s_rsp_valid), .s_rsp_ready(b_s_rsp_ready),
        .s_rsp_rdata(b_s_rsp_rdata), .busy(b_busy), .owner(b_owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_m_req_valid = '0; a_m_req_wen = '0; a_m_req_addr = '0;
        a_m_req_wdata = '0; a_m_req_wlen = '0; a_m_rsp_ready = '0;
        a_s_req_ready = 1'b0; a_s_rsp_valid = 1'b0; a_s_rsp_rdata = '0;
        b_m_req_valid = '0; b_m_req_wen = '0; b_m_req_addr = '0;
        b_m_req_wdata = '0; b_m_req_wlen = '0; b_m_rsp_ready = '0;
        b_s_req_ready = 1'b0; b_s_rsp_valid = 1'b0; b_s_rsp_rdata = '0;
        tick();
        tick();
        n_tests++;
        if ({a_busy, a_owner, a_s_req_valid, a_s_rsp_ready, a_m_rsp_valid, a_m_rsp_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_a_ctl: got %b want 0",
                     {a_busy, a_owner, a_s_req_valid, a_s_rsp_ready, a_m_rsp_valid, a_m_rsp_err});
        end
        n_tests++;
        if ({a_s_req_wen, a_s_req_addr, a_s_req_wdata, a_s_req_wlen} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_a_payload: got %h want 0", {a_s_req_addr, a_s_req_wdata});
        end
        n_tests++;
        if ({b_busy, b_owner, b_s_req_valid, b_m_rsp_valid, b_m_rsp_err} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_b_ctl: got %b want 0",
                     {b_busy, b_owner, b_s_req_valid, b_m_rsp_valid, b_m_rsp_err});
        end
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        logic r1_seen;
        r1_seen = 1'b0;
        tick();
        a_m_req_valid = 2'b01; a_m_req_addr[31:0] = 32'h8000_0000;
        a_s_req_ready = 1'b1; a_m_rsp_ready = 2'b11;
        #1;
        r1_seen |= a_m_req_ready[1];
        n_tests++;
        if (a_m_req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rd_grant: got %b want 01", a_m_req_ready);
        end
        tick();
        a_m_req_valid = 2'b00;
        #1;
        r1_seen |= a_m_req_ready[1];
        n_tests++;
        if ({a_s_req_valid, a_s_req_wen, a_s_req_addr, a_busy, a_owner} !== {2'b10, 32'h8000_0000, 2'b10}) begin
            n_fail++; $display("FAIL rd_req: got v%b addr %h want v1 addr 80000000", a_s_req_valid, a_s_req_addr);
        end
        tick();
        r1_seen |= a_m_req_ready[1];
        n_tests++;
        if (a_m_rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL rd_rsp_early: got %b want 00", a_m_rsp_valid);
        end
        tick();
        a_s_rsp_valid = 1'b1; a_s_rsp_rdata = 32'h0000_0413;
        #1;
        r1_seen |= a_m_req_ready[1];
        n_tests++;
        if ({a_m_rsp_valid, a_m_rsp_rdata, a_m_rsp_err, a_s_rsp_ready} !== {2'b01, 32'h0000_0413, 2'b01}) begin
            n_fail++; $display("FAIL rd_rsp: got v%b d%h e%b want v01 d413 e0", a_m_rsp_valid, a_m_rsp_rdata, a_m_rsp_err);
        end
        tick();
        a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_busy, a_m_rsp_valid} !== 3'b0) begin
            n_fail++; $display("FAIL rd_done: got busy %b want 0", a_busy);
        end
        n_tests++;
        if (r1_seen !== 1'b0) begin
            n_fail++; $display("FAIL rd_ch1_ready: got %b want 0", r1_seen);
        end
    endtask

    task automatic test_contention();
        logic       e;
        logic [1:0] oh;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        a_m_req_valid = 2'b11; a_m_req_wen = 2'b00;
        a_m_req_addr = {32'ha000_0000, 32'h8000_0000};
        a_s_req_ready = 1'b1; a_s_rsp_valid = 1'b1; a_s_rsp_rdata = 32'h55;
        a_m_rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            e  = 1'(i % 2);
            oh = 2'b01 << e;
            n_tests++;
            if (a_m_req_ready !== oh) begin
                n_fail++; $display("FAIL cont_grant%0d: got %b want %b", i, a_m_req_ready, oh);
            end
            tick();
            n_tests++;
            if ({a_owner, a_s_req_addr} !== {e, (e ? 32'ha000_0000 : 32'h8000_0000)}) begin
                n_fail++; $display("FAIL cont_req%0d: got o%b %h want o%b", i, a_owner, a_s_req_addr, e);
            end
            tick();
            n_tests++;
            if (a_m_rsp_valid !== oh) begin
                n_fail++; $display("FAIL cont_rsp%0d: got %b want %b", i, a_m_rsp_valid, oh);
            end
            tick();
        end
        a_m_req_valid = 2'b00; a_s_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        logic stall_bad;
        stall_bad = 1'b0;
        b_m_req_valid = 4'b1000; b_m_req_addr[127:96] = 32'h3000_0000;
        b_s_req_ready = 1'b1; b_s_rsp_valid = 1'b1; b_s_rsp_rdata = 32'h77;
        b_m_rsp_ready = 4'b1111;
        #1;
        n_tests++;
        if (b_m_req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_g3: got %b want 1000", b_m_req_ready);
        end
        tick();
        n_tests++;
        if ({b_owner, b_s_req_addr} !== {2'd3, 32'h3000_0000}) begin
            n_fail++; $display("FAIL wrap_req3: got o%0d %h want o3 30000000", b_owner, b_s_req_addr);
        end
        tick();
        tick();
        b_m_req_valid = 4'b1011;
        b_m_req_addr[31:0] = 32'h0000_1000; b_m_req_addr[63:32] = 32'h1000_0000;
        b_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (b_m_req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_g0: got %b want 0001", b_m_req_ready);
        end
        tick();
        b_m_req_valid = 4'b1010;
        #1;
        n_tests++;
        if ({b_owner, b_s_req_addr} !== {2'd0, 32'h0000_1000}) begin
            n_fail++; $display("FAIL wrap_req0: got o%0d %h want o0 00001000", b_owner, b_s_req_addr);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            if ({b_busy, b_m_rsp_err, b_m_rsp_valid} !== 6'b100000) stall_bad = 1'b1;
            tick();
        end
        n_tests++;
        if (stall_bad !== 1'b0) begin
            n_fail++; $display("FAIL wrap_nowd: got stall error %b want 0", stall_bad);
        end
        b_s_rsp_valid = 1'b1;
        #1;
        n_tests++;
        if ({b_m_rsp_valid, b_m_rsp_rdata} !== {4'b0001, 32'h77}) begin
            n_fail++; $display("FAIL wrap_rsp0: got %b %h want 0001 77", b_m_rsp_valid, b_m_rsp_rdata);
        end
        tick();
        b_m_req_valid = 4'b1001;
        #1;
        n_tests++;
        if (b_m_req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_g3b: got %b want 1000", b_m_req_ready);
        end
        tick();
        b_m_req_valid = 4'b0000;
        tick();
        tick();
        b_s_rsp_valid = 1'b0;
        #1;
    endtask

    task automatic test_write();
        a_m_req_valid = 2'b10; a_m_req_wen = 2'b10;
        a_m_req_addr  = {32'ha000_0010, 32'h1111_1111};
        a_m_req_wdata = {32'hdead_beef, 32'h2222_2222};
        a_m_req_wlen  = {3'b100, 3'b011};
        a_s_req_ready = 1'b0; a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_m_req_ready !== 2'b10) begin
            n_fail++; $display("FAIL wr_grant: got %b want 10", a_m_req_ready);
        end
        tick();
        a_m_req_valid = 2'b00; a_m_req_wen = 2'b00;
        a_m_req_addr = '0; a_m_req_wdata = '0; a_m_req_wlen = '0;
        #1;
        n_tests++;
        if ({a_s_req_valid, a_s_req_wen, a_s_req_addr, a_s_req_wdata, a_s_req_wlen, a_owner}
            !== {2'b11, 32'ha000_0010, 32'hdead_beef, 3'b100, 1'b1}) begin
            n_fail++; $display("FAIL wr_req: got w%b %h %h %b want w1 a0000010 deadbeef 100",
                               a_s_req_wen, a_s_req_addr, a_s_req_wdata, a_s_req_wlen);
        end
        tick();
        a_s_req_ready = 1'b1;
        #1;
        n_tests++;
        if ({a_s_req_valid, a_s_req_wdata} !== {1'b1, 32'hdead_beef}) begin
            n_fail++; $display("FAIL wr_hold: got v%b %h want v1 deadbeef", a_s_req_valid, a_s_req_wdata);
        end
        tick();
        a_s_req_ready = 1'b0; a_s_rsp_valid = 1'b1; a_s_rsp_rdata = '0;
        #1;
        n_tests++;
        if ({a_m_rsp_valid, a_m_rsp_err, a_s_rsp_ready, a_s_req_valid} !== 5'b10010) begin
            n_fail++; $display("FAIL wr_rsp: got v%b e%b r%b want v10 e0 r1", a_m_rsp_valid, a_m_rsp_err, a_s_rsp_ready);
        end
        tick();
        a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got busy %b want 0", a_busy);
        end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        a_m_req_valid = 2'b01; a_m_req_addr[31:0] = 32'h8000_0100;
        a_s_req_ready = 1'b1; a_m_rsp_ready = 2'b00;
        #1;
        tick();
        a_m_req_valid = 2'b00;
        #1;
        n_tests++;
        if (a_s_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL to_req: got %b want 1", a_s_req_valid);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            if ({a_busy, a_m_rsp_err, a_m_rsp_valid} !== 4'b1000) early = 1'b1;
        end
        n_tests++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL to_early: got early error %b want 0", early);
        end
        tick();
        n_tests++;
        if ({a_m_rsp_valid, a_m_rsp_err, a_m_rsp_rdata, a_s_req_valid} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL to_err: got v%b e%b d%h want v01 e1 d0", a_m_rsp_valid, a_m_rsp_err, a_m_rsp_rdata);
        end
        a_s_rsp_valid = 1'b1; a_s_rsp_rdata = 32'h1234_5678;
        #1;
        n_tests++;
        if ({a_s_rsp_ready, a_m_rsp_rdata, a_m_rsp_err} !== {1'b0, 32'h0, 1'b1}) begin
            n_fail++; $display("FAIL to_late: got r%b d%h want r0 d0", a_s_rsp_ready, a_m_rsp_rdata);
        end
        tick();
        n_tests++;
        if ({a_m_rsp_valid, a_m_rsp_err, a_busy} !== 4'b0111) begin
            n_fail++; $display("FAIL to_hold: got v%b e%b want v01 e1", a_m_rsp_valid, a_m_rsp_err);
        end
        a_m_rsp_ready = 2'b01;
        tick();
        a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_busy, a_m_rsp_err, a_m_rsp_valid} !== 4'b0) begin
            n_fail++; $display("FAIL to_idle: got b%b e%b v%b want 0", a_busy, a_m_rsp_err, a_m_rsp_valid);
        end
    endtask

    task automatic test_timeout_boundary();
        a_m_req_valid = 2'b10; a_m_req_addr[63:32] = 32'h8000_0200;
        a_s_req_ready = 1'b1; a_m_rsp_ready = 2'b11; a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_m_req_ready !== 2'b10) begin
            n_fail++; $display("FAIL tb_grant: got %b want 10", a_m_req_ready);
        end
        tick();
        a_m_req_valid = 2'b00;
        tick();
        tick();
        tick();
        a_s_rsp_valid = 1'b1; a_s_rsp_rdata = 32'hcafe_0001;
        #1;
        n_tests++;
        if ({a_m_rsp_valid, a_m_rsp_err, a_m_rsp_rdata} !== {2'b10, 1'b0, 32'hcafe_0001}) begin
            n_fail++; $display("FAIL tb_rsp: got v%b e%b d%h want v10 e0 cafe0001", a_m_rsp_valid, a_m_rsp_err, a_m_rsp_rdata);
        end
        tick();
        a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({a_busy, a_m_rsp_err, a_m_rsp_valid} !== 4'b0) begin
            n_fail++; $display("FAIL tb_nerr: got b%b e%b want 0", a_busy, a_m_rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        a_m_req_valid = 2'b01; a_m_req_addr[31:0] = 32'h8000_0300;
        a_s_req_ready = 1'b1; a_s_rsp_valid = 1'b1; a_m_rsp_ready = 2'b11;
        #1;
        tick();
        a_m_req_valid = 2'b00;
        tick();
        tick();
        a_m_req_valid = 2'b10; a_m_req_addr[63:32] = 32'ha000_0300;
        a_m_rsp_ready = 2'b01;
        #1;
        n_tests++;
        if (a_m_req_ready !== 2'b10) begin
            n_fail++; $display("FAIL rm_grant1: got %b want 10", a_m_req_ready);
        end
        tick();
        a_m_req_valid = 2'b00;
        tick();
        n_tests++;
        if ({a_m_rsp_valid, a_busy} !== 3'b101) begin
            n_fail++; $display("FAIL rm_pend: got v%b b%b want v10 b1", a_m_rsp_valid, a_busy);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({a_busy, a_owner, a_m_rsp_valid, a_s_rsp_ready, a_s_req_valid, a_m_rsp_err, a_s_req_addr}
            !== 39'h0) begin
            n_fail++; $display("FAIL rm_reset: got b%b o%b v%b r%b addr %h want all 0",
                               a_busy, a_owner, a_m_rsp_valid, a_s_rsp_ready, a_s_req_addr);
        end
        rst = 1'b1;
        a_m_req_valid = 2'b11; a_m_req_addr[31:0] = 32'h8000_0400;
        a_m_rsp_ready = 2'b11; a_s_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (a_m_req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rm_grant0: got %b want 01", a_m_req_ready);
        end
        tick();
        n_tests++;
        if ({a_owner, a_s_req_addr} !== {1'b0, 32'h8000_0400}) begin
            n_fail++; $display("FAIL rm_req0: got o%b %h want o0 80000400", a_owner, a_s_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wrap();
        test_write();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
